// File: rtl/i2s_rx_stereo48.sv
// I2S stereo receiver: deserialises signed L/R words from an asynchronous I2S link
// and re-times each pair to the 48 kHz system enable through a one-pair buffer.
module i2s_rx_stereo48 #(
    parameter int unsigned DATA_W      = 18,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clken48kHz,
    input  logic              i2s_sck,
    input  logic              i2s_ws,
    input  logic              i2s_sd,
    output logic [DATA_W-1:0] LEFTout,
    output logic [DATA_W-1:0] RIGHTout,
    output logic              sample_valid,
    output logic [CNT_W-1:0]  overrun_cnt,
    output logic [CNT_W-1:0]  underrun_cnt
);
    localparam int unsigned BC_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
    logic                   sck_d, ws_prev;
    logic                   sck_rise, ws_s, sd_s;

    logic [DATA_W-1:0] shift, word_c, left_hold, pend_l, pend_r;
    logic [BC_W-1:0]   bitcnt;
    logic              left_seen, pair_ready;

    logic ws_edge_c, left_close_c, right_close_c, pair_done_c;

    assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_d;
    assign ws_s     = ws_sync[SYNC_STAGES-1];
    assign sd_s     = sd_sync[SYNC_STAGES-1];

    // Current word with this rise's bit merged in (bitcnt saturates, so extra slot bits drop)
    always_comb begin
        word_c = shift;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (bitcnt == BC_W'(int'(DATA_W) - 1 - i)) word_c[i] = sd_s;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and word-close strobes; a WS edge closes the old word on its LSB rise
    always_comb begin
        state_nxt     = state;
        ws_edge_c     = 1'b0;
        left_close_c  = 1'b0;
        right_close_c = 1'b0;
        pair_done_c   = 1'b0;
        if (sck_rise && (ws_s != ws_prev)) begin
            ws_edge_c     = 1'b1;
            state_nxt     = ws_s ? RIGHT : LEFT;
            left_close_c  = (state == LEFT);
            right_close_c = (state == RIGHT);
            pair_done_c   = (state == RIGHT) && left_seen;
        end
    end

    // Pin synchronisers and serial capture
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_sync  <= '0;
            ws_sync   <= '0;
            sd_sync   <= '0;
            sck_d     <= 1'b0;
            ws_prev   <= 1'b0;
            shift     <= '0;
            bitcnt    <= '0;
            left_hold <= '0;
            left_seen <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], i2s_sck};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], i2s_ws};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], i2s_sd};
            sck_d    <= sck_sync[SYNC_STAGES-1];
            if (sck_rise) begin
                ws_prev <= ws_s;
                if (ws_edge_c) begin
                    shift  <= '0;
                    bitcnt <= '0;
                end else if (state != IDLE) begin
                    shift <= word_c;
                    if (bitcnt < BC_W'(DATA_W)) bitcnt <= bitcnt + BC_W'(1);
                end
                if (left_close_c) begin
                    left_hold <= word_c;
                    left_seen <= 1'b1;
                end else if (right_close_c) begin
                    left_seen <= 1'b0;
                end
            end
        end
    end

    // One-pair buffer, enable-timed outputs and saturating error counters
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_l       <= '0;
            pend_r       <= '0;
            pair_ready   <= 1'b0;
            LEFTout      <= '0;
            RIGHTout     <= '0;
            sample_valid <= 1'b0;
            overrun_cnt  <= '0;
            underrun_cnt <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (clken48kHz) begin
                if (pair_ready) begin
                    LEFTout      <= pend_l;
                    RIGHTout     <= pend_r;
                    sample_valid <= 1'b1;
                end else if (underrun_cnt != CNT_MAX) begin
                    underrun_cnt <= underrun_cnt + CNT_W'(1);
                end
            end
            if (pair_done_c) begin
                pend_l     <= left_hold;
                pend_r     <= word_c;
                pair_ready <= 1'b1;
                if (pair_ready && !clken48kHz && (overrun_cnt != CNT_MAX))
                    overrun_cnt <= overrun_cnt + CNT_W'(1);
            end else if (clken48kHz) begin
                pair_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_stereo48.sv
// Directed bench for i2s_rx_stereo48: drives I2S frames bit by bit and checks
// the re-timed pairs, valid pulses and error counters against hand-computed values.
module tb_i2s_rx_stereo48;
    localparam int unsigned DATA_W = 18;
    localparam int unsigned CNT_W  = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              clken48kHz;
    logic              i2s_sck, i2s_ws, i2s_sd;
    logic [DATA_W-1:0] LEFTout, RIGHTout;
    logic              sample_valid;
    logic [CNT_W-1:0]  overrun_cnt, underrun_cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic carry = 1'b0;
    logic              cap_sv;
    logic [DATA_W-1:0] cap_l, cap_r;

    i2s_rx_stereo48 #(.DATA_W(DATA_W), .SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .clken48kHz   (clken48kHz),
        .i2s_sck      (i2s_sck),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .LEFTout      (LEFTout),
        .RIGHTout     (RIGHTout),
        .sample_valid (sample_valid),
        .overrun_cnt  (overrun_cnt),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic slot_bit(input logic [31:0] w, input int nbits, input int j);
        logic b;
        b = 1'b0;
        if (j >= 0 && j < nbits) b = w[nbits-1-j];
        return b;
    endfunction

    // One SCK period: low 2 clocks, high 2 clocks; optional enable aligned to the rise being acted on
    task automatic send_bit(input logic ws, input logic sd, input bit en_on_rise);
        i2s_ws  = ws;
        i2s_sd  = sd;
        i2s_sck = 1'b0;
        repeat (2) @(negedge clock);
        i2s_sck = 1'b1;
        if (en_on_rise) begin
            repeat (2) @(negedge clock);
            clken48kHz = 1'b1;
            @(negedge clock);
            clken48kHz = 1'b0;
            cap_sv = sample_valid;
            cap_l  = LEFTout;
            cap_r  = RIGHTout;
        end else begin
            repeat (2) @(negedge clock);
        end
    endtask

    // Standard I2S slot: first bit carries the previous word's LSB, then MSB-first data
    task automatic send_slot(input logic ws, input logic [31:0] word, input int nbits,
                             input int slot, input bit en_first);
        for (int k = 0; k < slot; k++)
            send_bit(ws, (k == 0) ? carry : slot_bit(word, nbits, k - 1), en_first && (k == 0));
        carry = slot_bit(word, nbits, slot - 1);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits,
                              input int slot, input bit en_first);
        send_slot(1'b0, l, nbits, slot, en_first);
        send_slot(1'b1, r, nbits, slot, 1'b0);
    endtask

    task automatic pulse_en();
        clken48kHz = 1'b1;
        @(negedge clock);
        clken48kHz = 1'b0;
        cap_sv = sample_valid;
        cap_l  = LEFTout;
        cap_r  = RIGHTout;
    endtask

    task automatic check_cap(input string tag, input logic sv, input logic [31:0] l, input logic [31:0] r);
        check({tag, ".valid"}, 32'(cap_sv), 32'(sv));
        check({tag, ".left"},  32'(cap_l), l);
        check({tag, ".right"}, 32'(cap_r), r);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".left"},     32'(LEFTout), 32'h0);
        check({tag, ".right"},    32'(RIGHTout), 32'h0);
        check({tag, ".valid"},    32'(sample_valid), 32'h0);
        check({tag, ".overrun"},  32'(overrun_cnt), 32'h0);
        check({tag, ".underrun"}, 32'(underrun_cnt), 32'h0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        clken48kHz = 1'b0;
        i2s_sck    = 1'b0;
        i2s_ws     = 1'b0;
        i2s_sd     = 1'b0;
        repeat (4) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;

        // 64-SCK frames; first pair needs a WS edge, then a full L+R
        repeat (3) send_frame(32'h1ABCD, 32'h3FFFF, 18, 32, 1'b0);
        pulse_en();
        check_cap("f64a", 1'b1, 32'h1ABCD, 32'h3FFFF);
        @(negedge clock);
        check("f64a.valid_drop", 32'(sample_valid), 32'h0);
        send_frame(32'h1ABCD, 32'h3FFFF, 18, 32, 1'b0);
        pulse_en();
        check_cap("f64b", 1'b1, 32'h1ABCD, 32'h3FFFF);
        check("f64.overrun", 32'(overrun_cnt), 32'h0);
        check("f64.underrun", 32'(underrun_cnt), 32'h0);

        // 36-SCK frames: LSB arrives on the WS edge
        send_frame(32'h20001, 32'h00001, 18, 18, 1'b0);
        pulse_en();
        check_cap("f36a", 1'b1, 32'h1ABCD, 32'h3FFFF);
        send_frame(32'h20001, 32'h00001, 18, 18, 1'b0);
        pulse_en();
        check_cap("f36b", 1'b1, 32'h20001, 32'h00001);

        // 16-bit words come out left-justified
        send_frame(32'h8001, 32'h1234, 16, 32, 1'b0);
        pulse_en();
        check_cap("w16a", 1'b1, 32'h20001, 32'h00001);
        send_frame(32'h8001, 32'h1234, 16, 32, 1'b0);
        pulse_en();
        check_cap("w16b", 1'b1, 32'h20004, 32'h048D0);

        // Pair completes on the enable cycle while a pair is pending
        send_frame(32'h15555, 32'h2AAAA, 18, 18, 1'b0);
        send_frame(32'h00F0F, 32'h3C3C3, 18, 18, 1'b1);
        check_cap("coinc.old", 1'b1, 32'h20004, 32'h048D0);
        pulse_en();
        check_cap("coinc.new", 1'b1, 32'h15555, 32'h2AAAA);
        check("coinc.overrun", 32'(overrun_cnt), 32'h0);
        check("coinc.underrun", 32'(underrun_cnt), 32'h0);

        // SCK stopped: underruns with outputs held
        for (int i = 0; i < 3; i++) begin
            pulse_en();
            check_cap("stall", 1'b0, 32'h15555, 32'h2AAAA);
        end
        check("stall.underrun", 32'(underrun_cnt), 32'h3);

        // 300 pairs with no enable: overrun saturates
        for (int i = 0; i < 300; i++) send_frame(32'h0A5A5, 32'h35A5A, 18, 18, 1'b0);
        check("flood.overrun", 32'(overrun_cnt), 32'hFF);
        check("flood.underrun", 32'(underrun_cnt), 32'h3);
        pulse_en();
        check_cap("flood.out", 1'b1, 32'h0A5A5, 32'h35A5A);

        // Reset in the middle of a LEFT slot
        for (int k = 0; k < 5; k++) send_bit(1'b0, (k == 0) ? carry : 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check_zero("midreset");
        reset = 1'b0;
        send_frame(32'h12345, 32'h2468A, 18, 32, 1'b0);
        send_frame(32'h11111, 32'h22222, 18, 32, 1'b0);
        pulse_en();
        check_cap("rst.nopair", 1'b0, 32'h0, 32'h0);
        check("rst.underrun", 32'(underrun_cnt), 32'h1);
        send_frame(32'h11111, 32'h22222, 18, 32, 1'b0);
        pulse_en();
        check_cap("rst.first", 1'b1, 32'h11111, 32'h22222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
